// File: rtl/doorlock_pkg.sv
// Shared constants for the door-lock password datapath: default geometry,
// factory master password and the compare FSM state encoding.
package doorlock_pkg;

    localparam int MAX_DIGITS_DEF = 8;
    localparam int DIGIT_W_DEF    = 4;
    localparam int MASTER_LEN_DEF = 4;

    localparam logic [31:0] MASTER_PSW_DEF = 32'h0000_2580;

    typedef logic [1:0] cmp_state_t;

    localparam cmp_state_t ST_IDLE = 2'b00;
    localparam cmp_state_t ST_CMP  = 2'b01;
    localparam cmp_state_t ST_DONE = 2'b10;

endpackage

// File: rtl/psw_shift_reg.sv
// One password store: a left-shifting register of decimal digits with a
// length counter that saturates at MAX_DIGITS.
module psw_shift_reg
    import doorlock_pkg::*;
#(
    parameter int MAX_DIGITS = MAX_DIGITS_DEF,
    parameter int DIGIT_W    = DIGIT_W_DEF,
    localparam int LEN_W     = $clog2(MAX_DIGITS + 1),
    localparam int STORE_W   = MAX_DIGITS * DIGIT_W
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               clr_i,
    input  logic               shift_i,
    input  logic [DIGIT_W-1:0] digit_i,
    output logic [STORE_W-1:0] digits_o,
    output logic [LEN_W-1:0]   len_o,
    output logic               limit_o
);

    logic [STORE_W-1:0] digits_q, digits_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               full;

    assign full = (len_q == LEN_W'(MAX_DIGITS));

    // Clear wins over shift; a full store silently drops further digits.
    always_comb begin
        digits_d = digits_q;
        len_d    = len_q;
        if (clr_i) begin
            digits_d = '0;
            len_d    = '0;
        end else if (shift_i && !full) begin
            digits_d = {digits_q[STORE_W-DIGIT_W-1:0], digit_i};
            len_d    = len_q + LEN_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            digits_q <= '0;
            len_q    <= '0;
        end else begin
            digits_q <= digits_d;
            len_q    <= len_d;
        end
    end

    assign digits_o = digits_q;
    assign len_o    = len_q;
    assign limit_o  = full;

endmodule

// File: rtl/psw_store_ctrl.sv
// Entry buffer and stored password with a digit-serial comparator that checks
// the buffer against both the stored password and the master password.
module psw_store_ctrl
    import doorlock_pkg::*;
#(
    parameter int MAX_DIGITS = MAX_DIGITS_DEF,
    parameter int DIGIT_W    = DIGIT_W_DEF,
    parameter int MASTER_LEN = MASTER_LEN_DEF,
    parameter logic [MAX_DIGITS*DIGIT_W-1:0] MASTER_PSW =
        (MAX_DIGITS*DIGIT_W)'(MASTER_PSW_DEF)
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               write_to_mem_i,
    input  logic               input_rst_i,
    input  logic               input_sl_i,
    input  logic [DIGIT_W-1:0] digit_i,
    input  logic               cmp_start_i,
    output logic               cmp_busy_o,
    output logic               cmp_done_o,
    output logic               same_o,
    output logic               master_same_o,
    output logic               buff_limit_o,
    output logic               mem_limit_o,
    output logic               digit_err_o
);

    localparam int LEN_W   = $clog2(MAX_DIGITS + 1);
    localparam int STORE_W = MAX_DIGITS * DIGIT_W;
    localparam int IDX_W   = (MAX_DIGITS > 1) ? $clog2(MAX_DIGITS) : 1;

    logic [STORE_W-1:0] buff_digits, mem_digits;
    logic [LEN_W-1:0]   buff_len, mem_len;
    logic               buff_limit, mem_limit;

    logic idle, digit_ok, sel_limit;
    logic sel_clr, sel_shift;

    cmp_state_t       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             eq_q, eq_d;
    logic             meq_q, meq_d;
    logic             same_q, same_d;
    logic             master_same_q, master_same_d;
    logic             digit_err_q, digit_err_d;

    logic [DIGIT_W-1:0] buff_dig, mem_dig, master_dig;

    assign idle      = (state_q == ST_IDLE);
    assign digit_ok  = (digit_i <= DIGIT_W'(9));
    assign sel_limit = write_to_mem_i ? mem_limit : buff_limit;

    // Store edits are only honoured while no compare is running.
    assign sel_clr   = idle && input_rst_i;
    assign sel_shift = idle && input_sl_i && !input_rst_i && digit_ok;

    psw_shift_reg #(
        .MAX_DIGITS (MAX_DIGITS),
        .DIGIT_W    (DIGIT_W)
    ) u_buff (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .clr_i    (sel_clr && !write_to_mem_i),
        .shift_i  (sel_shift && !write_to_mem_i),
        .digit_i  (digit_i),
        .digits_o (buff_digits),
        .len_o    (buff_len),
        .limit_o  (buff_limit)
    );

    psw_shift_reg #(
        .MAX_DIGITS (MAX_DIGITS),
        .DIGIT_W    (DIGIT_W)
    ) u_mem (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .clr_i    (sel_clr && write_to_mem_i),
        .shift_i  (sel_shift && write_to_mem_i),
        .digit_i  (digit_i),
        .digits_o (mem_digits),
        .len_o    (mem_len),
        .limit_o  (mem_limit)
    );

    assign buff_dig   = buff_digits[idx_q*DIGIT_W +: DIGIT_W];
    assign mem_dig    = mem_digits[idx_q*DIGIT_W +: DIGIT_W];
    assign master_dig = MASTER_PSW[idx_q*DIGIT_W +: DIGIT_W];

    // A digit dropped because the store is full is not treated as an error.
    assign digit_err_d = idle && input_sl_i && !input_rst_i && !digit_ok && !sel_limit;

    // Length mismatch is folded into eq/meq up front, so the digit walk only
    // has to clear them; results land in same/master_same on the way to DONE.
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        eq_d          = eq_q;
        meq_d         = meq_q;
        same_d        = same_q;
        master_same_d = master_same_q;
        case (state_q)
            ST_IDLE: begin
                if (cmp_start_i) begin
                    state_d       = ST_CMP;
                    idx_d         = '0;
                    same_d        = 1'b0;
                    master_same_d = 1'b0;
                    eq_d          = (buff_len == mem_len) && (mem_len != '0);
                    meq_d         = (buff_len == LEN_W'(MASTER_LEN));
                end
            end
            ST_CMP: begin
                eq_d  = eq_q && (buff_dig == mem_dig);
                meq_d = meq_q && (buff_dig == master_dig);
                idx_d = idx_q + IDX_W'(1);
                if (idx_q == IDX_W'(MAX_DIGITS - 1)) begin
                    state_d       = ST_DONE;
                    idx_d         = '0;
                    same_d        = eq_d;
                    master_same_d = meq_d;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q       <= ST_IDLE;
            idx_q         <= '0;
            eq_q          <= 1'b0;
            meq_q         <= 1'b0;
            same_q        <= 1'b0;
            master_same_q <= 1'b0;
            digit_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            eq_q          <= eq_d;
            meq_q         <= meq_d;
            same_q        <= same_d;
            master_same_q <= master_same_d;
            digit_err_q   <= digit_err_d;
        end
    end

    assign cmp_busy_o    = !idle;
    assign cmp_done_o    = (state_q == ST_DONE);
    assign same_o        = same_q;
    assign master_same_o = master_same_q;
    assign buff_limit_o  = buff_limit;
    assign mem_limit_o   = mem_limit;
    assign digit_err_o   = digit_err_q;

endmodule

// File: tb/tb_psw_store_ctrl.sv
// Directed bench for psw_store_ctrl with hand-computed expectations.
module tb_psw_store_ctrl;

    logic       clk_i = 1'b0;
    logic       reset_i = 1'b1;
    logic       write_to_mem_i = 1'b0;
    logic       input_rst_i = 1'b0;
    logic       input_sl_i = 1'b0;
    logic [3:0] digit_i = 4'd0;
    logic       cmp_start_i = 1'b0;
    logic       cmp_busy_o, cmp_done_o, same_o, master_same_o;
    logic       buff_limit_o, mem_limit_o, digit_err_o;

    int n_vec  = 0;
    int n_miss = 0;

    psw_store_ctrl dut (
        .clk_i          (clk_i),
        .reset_i        (reset_i),
        .write_to_mem_i (write_to_mem_i),
        .input_rst_i    (input_rst_i),
        .input_sl_i     (input_sl_i),
        .digit_i        (digit_i),
        .cmp_start_i    (cmp_start_i),
        .cmp_busy_o     (cmp_busy_o),
        .cmp_done_o     (cmp_done_o),
        .same_o         (same_o),
        .master_same_o  (master_same_o),
        .buff_limit_o   (buff_limit_o),
        .mem_limit_o    (mem_limit_o),
        .digit_err_o    (digit_err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic shift_in(input logic to_mem, input logic [3:0] d);
        @(negedge clk_i);
        write_to_mem_i = to_mem;
        input_sl_i     = 1'b1;
        digit_i        = d;
        @(negedge clk_i);
        input_sl_i     = 1'b0;
        digit_i        = 4'd0;
    endtask

    task automatic clear_store(input logic to_mem);
        @(negedge clk_i);
        write_to_mem_i = to_mem;
        input_rst_i    = 1'b1;
        @(negedge clk_i);
        input_rst_i    = 1'b0;
    endtask

    task automatic load_1234(input logic to_mem);
        clear_store(to_mem);
        shift_in(to_mem, 4'd1);
        shift_in(to_mem, 4'd2);
        shift_in(to_mem, 4'd3);
        shift_in(to_mem, 4'd4);
    endtask

    task automatic run_compare(output int cyc);
        @(negedge clk_i);
        cmp_start_i = 1'b1;
        @(negedge clk_i);
        cmp_start_i = 1'b0;
        cyc = 1;
        while (cmp_done_o !== 1'b1 && cyc < 20) begin
            @(negedge clk_i);
            cyc++;
        end
    endtask

    task automatic test_reset();
        @(negedge clk_i);
        n_vec++; if ({cmp_busy_o, cmp_done_o, same_o, master_same_o} !== 4'b0000) begin
            n_miss++; $display("FAIL reset_fsm_outs: got %b expected 0000",
                               {cmp_busy_o, cmp_done_o, same_o, master_same_o});
        end
        n_vec++; if ({buff_limit_o, mem_limit_o, digit_err_o} !== 3'b000) begin
            n_miss++; $display("FAIL reset_store_outs: got %b expected 000",
                               {buff_limit_o, mem_limit_o, digit_err_o});
        end
        n_vec++; if (dut.buff_len !== 4'd0 || dut.mem_len !== 4'd0) begin
            n_miss++; $display("FAIL reset_lens: got %0d/%0d expected 0/0", dut.buff_len, dut.mem_len);
        end
        reset_i = 1'b0;
    endtask

    task automatic test_match();
        int cyc;
        load_1234(1'b1);
        load_1234(1'b0);
        n_vec++; if (dut.mem_digits !== 32'h0000_1234 || dut.mem_len !== 4'd4) begin
            n_miss++; $display("FAIL mem_load: got %h len %0d expected 00001234 len 4",
                               dut.mem_digits, dut.mem_len);
        end
        run_compare(cyc);
        n_vec++; if (cyc != 9) begin
            n_miss++; $display("FAIL match_done_cycle: got %0d expected 9", cyc);
        end
        @(negedge clk_i);
        n_vec++; if ({same_o, master_same_o, cmp_busy_o, cmp_done_o} !== 4'b1000) begin
            n_miss++; $display("FAIL match_result: got %b expected 1000",
                               {same_o, master_same_o, cmp_busy_o, cmp_done_o});
        end
    endtask

    task automatic test_master();
        int cyc;
        clear_store(1'b0);
        shift_in(1'b0, 4'd2);
        shift_in(1'b0, 4'd5);
        shift_in(1'b0, 4'd8);
        shift_in(1'b0, 4'd0);
        run_compare(cyc);
        n_vec++; if (cyc != 9) begin
            n_miss++; $display("FAIL master_done_cycle: got %0d expected 9", cyc);
        end
        @(negedge clk_i);
        n_vec++; if ({same_o, master_same_o} !== 2'b01) begin
            n_miss++; $display("FAIL master_result: got %b expected 01", {same_o, master_same_o});
        end
        repeat (3) @(negedge clk_i);
        n_vec++; if ({same_o, master_same_o} !== 2'b01) begin
            n_miss++; $display("FAIL master_hold: got %b expected 01", {same_o, master_same_o});
        end
    endtask

    task automatic test_busy_ignore();
        int cyc;
        load_1234(1'b0);
        @(negedge clk_i);
        cmp_start_i = 1'b1;
        @(negedge clk_i);
        cmp_start_i = 1'b0;
        cyc = 1;
        n_vec++; if (cmp_busy_o !== 1'b1) begin
            n_miss++; $display("FAIL busy_flag: got %b expected 1", cmp_busy_o);
        end
        write_to_mem_i = 1'b0; input_sl_i = 1'b1; digit_i = 4'd9;
        @(negedge clk_i); cyc++;
        input_sl_i = 1'b0; write_to_mem_i = 1'b1; input_rst_i = 1'b1;
        @(negedge clk_i); cyc++;
        input_rst_i = 1'b0; cmp_start_i = 1'b1;
        @(negedge clk_i); cyc++;
        cmp_start_i = 1'b0; write_to_mem_i = 1'b0; input_sl_i = 1'b1; digit_i = 4'hA;
        @(negedge clk_i); cyc++;
        input_sl_i = 1'b0; digit_i = 4'd0;
        n_vec++; if (digit_err_o !== 1'b0) begin
            n_miss++; $display("FAIL busy_no_err: got %b expected 0", digit_err_o);
        end
        while (cmp_done_o !== 1'b1 && cyc < 20) begin
            @(negedge clk_i);
            cyc++;
        end
        n_vec++; if (cyc != 9) begin
            n_miss++; $display("FAIL busy_done_cycle: got %0d expected 9", cyc);
        end
        @(negedge clk_i);
        n_vec++; if ({same_o, master_same_o} !== 2'b10) begin
            n_miss++; $display("FAIL busy_result: got %b expected 10", {same_o, master_same_o});
        end
        n_vec++; if (dut.buff_digits !== 32'h0000_1234 || dut.buff_len !== 4'd4 || dut.mem_len !== 4'd4) begin
            n_miss++; $display("FAIL busy_stores: buf %h len %0d mem len %0d expected 00001234 4 4",
                               dut.buff_digits, dut.buff_len, dut.mem_len);
        end
    endtask

    task automatic test_limit();
        clear_store(1'b0);
        for (int i = 1; i <= 7; i++) shift_in(1'b0, 4'(i));
        n_vec++; if (buff_limit_o !== 1'b0) begin
            n_miss++; $display("FAIL limit_after7: got %b expected 0", buff_limit_o);
        end
        shift_in(1'b0, 4'd8);
        n_vec++; if (buff_limit_o !== 1'b1 || dut.buff_len !== 4'd8) begin
            n_miss++; $display("FAIL limit_after8: got %b len %0d expected 1 len 8", buff_limit_o, dut.buff_len);
        end
        shift_in(1'b0, 4'd9);
        n_vec++; if (dut.buff_digits !== 32'h1234_5678 || dut.buff_len !== 4'd8) begin
            n_miss++; $display("FAIL limit_ninth: got %h len %0d expected 12345678 len 8",
                               dut.buff_digits, dut.buff_len);
        end
        n_vec++; if (digit_err_o !== 1'b0 || mem_limit_o !== 1'b0) begin
            n_miss++; $display("FAIL limit_flags: err %b mem_limit %b expected 0 0", digit_err_o, mem_limit_o);
        end
    endtask

    task automatic test_digit_err();
        clear_store(1'b0);
        shift_in(1'b0, 4'd5);
        shift_in(1'b0, 4'd6);
        shift_in(1'b0, 4'hA);
        n_vec++; if (digit_err_o !== 1'b1) begin
            n_miss++; $display("FAIL err_pulse: got %b expected 1", digit_err_o);
        end
        n_vec++; if (dut.buff_digits !== 32'h0000_0056 || dut.buff_len !== 4'd2) begin
            n_miss++; $display("FAIL err_store: got %h len %0d expected 00000056 len 2",
                               dut.buff_digits, dut.buff_len);
        end
        @(negedge clk_i);
        n_vec++; if (digit_err_o !== 1'b0) begin
            n_miss++; $display("FAIL err_one_cycle: got %b expected 0", digit_err_o);
        end
        write_to_mem_i = 1'b0; input_rst_i = 1'b1; input_sl_i = 1'b1; digit_i = 4'd7;
        @(negedge clk_i);
        input_rst_i = 1'b0; input_sl_i = 1'b0; digit_i = 4'd0;
        n_vec++; if (dut.buff_digits !== 32'h0 || dut.buff_len !== 4'd0) begin
            n_miss++; $display("FAIL rst_priority: got %h len %0d expected 0 len 0",
                               dut.buff_digits, dut.buff_len);
        end
    endtask

    task automatic test_empty();
        int cyc;
        @(negedge clk_i); reset_i = 1'b1;
        @(negedge clk_i); reset_i = 1'b0;
        run_compare(cyc);
        @(negedge clk_i);
        n_vec++; if (cyc != 9 || {same_o, master_same_o} !== 2'b00) begin
            n_miss++; $display("FAIL empty_cmp: cycle %0d result %b expected 9 00", cyc, {same_o, master_same_o});
        end
        load_1234(1'b1);
        clear_store(1'b0);
        shift_in(1'b0, 4'd1);
        shift_in(1'b0, 4'd2);
        shift_in(1'b0, 4'd3);
        run_compare(cyc);
        @(negedge clk_i);
        n_vec++; if ({same_o, master_same_o} !== 2'b00) begin
            n_miss++; $display("FAIL short_buf: got %b expected 00", {same_o, master_same_o});
        end
    endtask

    task automatic test_reset_mid();
        bit seen_done;
        load_1234(1'b1);
        load_1234(1'b0);
        @(negedge clk_i);
        cmp_start_i = 1'b1;
        @(negedge clk_i);
        cmp_start_i = 1'b0;
        repeat (3) @(negedge clk_i);
        #2 reset_i = 1'b1;
        #1;
        n_vec++; if ({cmp_busy_o, cmp_done_o, same_o, master_same_o} !== 4'b0000) begin
            n_miss++; $display("FAIL midreset_outs: got %b expected 0000",
                               {cmp_busy_o, cmp_done_o, same_o, master_same_o});
        end
        n_vec++; if (dut.buff_digits !== 32'h0 || dut.mem_digits !== 32'h0 ||
                     dut.buff_len !== 4'd0 || dut.mem_len !== 4'd0) begin
            n_miss++; $display("FAIL midreset_stores: buf %h/%0d mem %h/%0d expected all 0",
                               dut.buff_digits, dut.buff_len, dut.mem_digits, dut.mem_len);
        end
        @(negedge clk_i);
        reset_i = 1'b0;
        seen_done = 1'b0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk_i);
            if (cmp_done_o === 1'b1 || cmp_busy_o === 1'b1) seen_done = 1'b1;
        end
        n_vec++; if (seen_done) begin
            n_miss++; $display("FAIL midreset_no_done: got activity 1 expected 0");
        end
    endtask

    initial begin
        test_reset();
        test_match();
        test_master();
        test_busy_ignore();
        test_limit();
        test_digit_err();
        test_empty();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
